// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the MEM stage and data_mem_pipe.
//   req_valid/req_ready   request handshake (accept when both high)
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          loads: 1 = zero-extend, 0 = sign-extend
//   req_addr/req_wdata    byte address, right-aligned store data
//   stall                 freezes the memory pipeline
//   rsp_valid/rdata/fault response for the oldest accepted request
// Modports: master = requester (MEM stage), slave = memory.
interface data_mem_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  stall;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic [1:0]            rsp_fault;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, stall,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, stall,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: pipelined 32-bit data memory for the MEM stage.
// Synchronous-read word array with byte-enable stores, valid/stall handshake,
// misalignment / out-of-range fault reporting and a read latency of 1 or 2.
// Ports:
//   clk   clock
//   rst   synchronous reset, active low
//   bus   data_mem_if.slave (request in, response out)
// Load attributes (size, unsigned, offset) travel with the read word so the
// extracted result never depends on the request presented in the current cycle.
module data_mem_pipe #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    data_mem_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int WORD_W = ADDR_WIDTH - 2;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic [WORD_W-1:0] word;
    logic [1:0]        off;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        fault;
    logic [3:0]        be;
    logic [31:0]       wdata_lane;
    logic              write_en;
    logic              read_en;

    logic [31:0]       rdata_q;
    logic              s1_valid;
    logic              s1_write;
    logic [1:0]        s1_size;
    logic              s1_unsigned;
    logic [1:0]        s1_off;
    logic [1:0]        s1_fault;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       ext;

    assign bus.req_ready = rst & ~bus.stall;
    assign accept        = bus.req_valid & bus.req_ready;
    assign word          = bus.req_addr[ADDR_WIDTH-1:2];
    assign off           = bus.req_addr[1:0];
    assign idx           = word[IDX_W-1:0];

    // Alignment is checked before range, so a misaligned out-of-range access reports 01.
    always_comb begin
        fault = 2'b00;
        if (bus.req_size == 2'b11 ||
            (bus.req_size == 2'b01 && off[0]) ||
            (bus.req_size == 2'b10 && off != 2'b00)) begin
            fault = 2'b01;
        end else if ({1'b0, word} >= (WORD_W+1)'(DEPTH_WORDS)) begin
            fault = 2'b10;
        end
    end

    // Replicating the narrow data across the word puts it in every lane the
    // byte enables can select.
    always_comb begin
        be         = 4'b0000;
        wdata_lane = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be         = 4'b0001 << off;
                wdata_lane = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << off;
                wdata_lane = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign write_en = accept & bus.req_write & (fault == 2'b00);
    assign read_en  = accept & ~bus.req_write;

    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    // Plain synchronous read; a store accepted the previous cycle is already in the array.
    always_ff @(posedge clk) begin
        if (read_en) rdata_q <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_write    <= 1'b0;
            s1_size     <= 2'b00;
            s1_unsigned <= 1'b0;
            s1_off      <= 2'b00;
            s1_fault    <= 2'b00;
        end else if (!bus.stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_write    <= bus.req_write;
                s1_size     <= bus.req_size;
                s1_unsigned <= bus.req_unsigned;
                s1_off      <= off;
                s1_fault    <= fault;
            end
        end
    end

    always_comb begin
        byte_sel = rdata_q[{s1_off, 3'b000} +: 8];
        half_sel = rdata_q[{s1_off[1], 4'b0000} +: 16];
        case (s1_size)
            2'b00:   ext = s1_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ext = s1_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ext = rdata_q;
        endcase
        if (!s1_valid || s1_write || s1_fault != 2'b00) ext = 32'h0;
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign bus.rsp_valid = s1_valid;
        assign bus.rsp_rdata = ext;
        assign bus.rsp_fault = s1_valid ? s1_fault : 2'b00;
    end else if (READ_LATENCY == 2) begin : g_lat2
        logic        s2_valid;
        logic [31:0] s2_rdata;
        logic [1:0]  s2_fault;

        always_ff @(posedge clk) begin
            if (!rst) begin
                s2_valid <= 1'b0;
                s2_rdata <= 32'h0;
                s2_fault <= 2'b00;
            end else if (!bus.stall) begin
                s2_valid <= s1_valid;
                s2_rdata <= ext;
                s2_fault <= s1_valid ? s1_fault : 2'b00;
            end
        end

        assign bus.rsp_valid = s2_valid;
        assign bus.rsp_rdata = s2_rdata;
        assign bus.rsp_fault = s2_fault;
    end else begin : g_bad_latency
        $error("data_mem_pipe: READ_LATENCY must be 1 or 2");
    end
endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: drives identical traffic into a latency-1 and a latency-2
// instance; checks responses against hand-computed values.
module tb_data_mem_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_if #(.ADDR_WIDTH(12)) if1 ();
    data_mem_if #(.ADDR_WIDTH(12)) if2 ();

    assign if1.req_valid    = req_valid;
    assign if1.req_write    = req_write;
    assign if1.req_size     = req_size;
    assign if1.req_unsigned = req_unsigned;
    assign if1.req_addr     = req_addr;
    assign if1.req_wdata    = req_wdata;
    assign if1.stall        = stall;
    assign if2.req_valid    = req_valid;
    assign if2.req_write    = req_write;
    assign if2.req_size     = req_size;
    assign if2.req_unsigned = req_unsigned;
    assign if2.req_addr     = req_addr;
    assign if2.req_wdata    = req_wdata;
    assign if2.stall        = stall;

    data_mem_pipe #(.ADDR_WIDTH(12), .DEPTH_WORDS(256), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    data_mem_pipe #(.ADDR_WIDTH(12), .DEPTH_WORDS(256), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .bus(if2.slave)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] erd;
        logic [1:0]  eflt;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic [31:0] erd, input logic [1:0] eflt);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.erd = erd; v.eflt = eflt;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic ev, input logic [31:0] ed, input logic [1:0] ef);
        chk({nm, "_l1_valid"}, {31'h0, if1.rsp_valid}, {31'h0, ev});
        chk({nm, "_l1_rdata"}, if1.rsp_rdata, ed);
        chk({nm, "_l1_fault"}, {30'h0, if1.rsp_fault}, {30'h0, ef});
    endtask

    task automatic chk2(input string nm, input logic ev, input logic [31:0] ed, input logic [1:0] ef);
        chk({nm, "_l2_valid"}, {31'h0, if2.rsp_valid}, {31'h0, ev});
        chk({nm, "_l2_rdata"}, if2.rsp_rdata, ed);
        chk({nm, "_l2_fault"}, {30'h0, if2.rsp_fault}, {30'h0, ef});
    endtask

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_write    = v.wr;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    task automatic drive_lw(input logic [11:0] a);
        drive(mk(1'b0, 2'b10, 1'b0, a, 32'h0, 32'h0, 2'b00));
    endtask

    initial begin
        vecs[0]  = mk(1, 2'b10, 0, 12'h000, 32'h11223344, 32'h0, 2'b00);
        vecs[1]  = mk(1, 2'b10, 0, 12'h004, 32'h10000004, 32'h0, 2'b00);
        vecs[2]  = mk(1, 2'b10, 0, 12'h008, 32'h20000008, 32'h0, 2'b00);
        vecs[3]  = mk(1, 2'b10, 0, 12'h00C, 32'h3000000C, 32'h0, 2'b00);
        vecs[4]  = mk(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 2'b00);
        vecs[5]  = mk(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 2'b00);
        vecs[6]  = mk(1, 2'b00, 0, 12'h013, 32'h000007F5, 32'h0, 2'b00);
        vecs[7]  = mk(0, 2'b00, 0, 12'h013, 32'h0, 32'hFFFFFFF5, 2'b00);
        vecs[8]  = mk(0, 2'b00, 1, 12'h013, 32'h0, 32'h000000F5, 2'b00);
        vecs[9]  = mk(0, 2'b10, 0, 12'h010, 32'h0, 32'hF5ADBEEF, 2'b00);
        vecs[10] = mk(0, 2'b01, 0, 12'h011, 32'h0, 32'h0, 2'b01);
        vecs[11] = mk(1, 2'b10, 0, 12'h402, 32'h12345678, 32'h0, 2'b01);
        vecs[12] = mk(1, 2'b10, 0, 12'h012, 32'h55555555, 32'h0, 2'b01);
        vecs[13] = mk(0, 2'b10, 0, 12'h010, 32'h0, 32'hF5ADBEEF, 2'b00);
        vecs[14] = mk(0, 2'b10, 0, 12'h000, 32'h0, 32'h11223344, 2'b00);
        vecs[15] = mk(0, 2'b10, 0, 12'h400, 32'h0, 32'h0, 2'b10);
        vecs[16] = mk(1, 2'b01, 0, 12'h002, 32'h0000ABCD, 32'h0, 2'b00);
        vecs[17] = mk(0, 2'b01, 0, 12'h002, 32'h0, 32'hFFFFABCD, 2'b00);
        vecs[18] = mk(0, 2'b01, 1, 12'h002, 32'h0, 32'h0000ABCD, 2'b00);
        vecs[19] = mk(0, 2'b01, 0, 12'h000, 32'h0, 32'h00003344, 2'b00);
        vecs[20] = mk(0, 2'b00, 0, 12'h001, 32'h0, 32'h00000033, 2'b00);
        vecs[21] = mk(0, 2'b11, 0, 12'h000, 32'h0, 32'h0, 2'b01);
        vecs[22] = mk(1, 2'b10, 0, 12'h3FC, 32'hCAFEF00D, 32'h0, 2'b00);
        vecs[23] = mk(0, 2'b10, 0, 12'h3FC, 32'h0, 32'hCAFEF00D, 2'b00);
        vecs[24] = mk(0, 2'b00, 0, 12'h3FE, 32'h0, 32'hFFFFFFFE, 2'b00);
        vecs[25] = mk(1, 2'b00, 0, 12'hFFC, 32'h00000080, 32'h0, 2'b10);
        vecs[26] = mk(0, 2'b10, 0, 12'h3FC, 32'h0, 32'hCAFEF00D, 2'b00);
        vecs[27] = mk(0, 2'b10, 0, 12'h000, 32'h0, 32'hABCD3344, 2'b00);

        rst = 1'b0; stall = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 12'h0; req_wdata = 32'h0;

        // Reset state
        repeat (3) tick();
        chk1("reset", 1'b0, 32'h0, 2'b00);
        chk2("reset", 1'b0, 32'h0, 2'b00);
        chk("reset_ready", {31'h0, if1.req_ready}, 32'h0);
        rst = 1'b1;
        #1;
        chk("ready_after_reset", {31'h0, if1.req_ready}, 32'h1);

        // Back-to-back table; latency-2 instance shows the previous vector
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            tick();
            chk1($sformatf("vec%0d", i), 1'b1, vecs[i].erd, vecs[i].eflt);
            if (i > 0) chk2($sformatf("vec%0d", i - 1), 1'b1, vecs[i-1].erd, vecs[i-1].eflt);
        end
        req_valid = 1'b0;
        tick();
        chk1("idle0", 1'b0, 32'h0, 2'b00);
        chk2($sformatf("vec%0d", NV - 1), 1'b1, vecs[NV-1].erd, vecs[NV-1].eflt);
        tick();
        chk2("idle1", 1'b0, 32'h0, 2'b00);

        // Latency-2 stream with a 3-cycle stall on the third request
        drive_lw(12'h000);
        tick();
        chk1("st_r0", 1'b1, 32'hABCD3344, 2'b00);
        drive_lw(12'h004);
        tick();
        chk2("st_r0", 1'b1, 32'hABCD3344, 2'b00);
        drive_lw(12'h008);
        stall = 1'b1;
        #1;
        chk("st_ready_stall", {31'h0, if2.req_ready}, 32'h0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk2($sformatf("st_hold%0d", s), 1'b1, 32'hABCD3344, 2'b00);
            chk1($sformatf("st_hold%0d", s), 1'b1, 32'h10000004, 2'b00);
            chk($sformatf("st_ready_hold%0d", s), {31'h0, if2.req_ready}, 32'h0);
        end
        stall = 1'b0;
        tick();
        chk2("st_r1", 1'b1, 32'h10000004, 2'b00);
        drive_lw(12'h00C);
        tick();
        chk2("st_r2", 1'b1, 32'h20000008, 2'b00);
        req_valid = 1'b0;
        tick();
        chk2("st_r3", 1'b1, 32'h3000000C, 2'b00);
        tick();
        chk2("st_end", 1'b0, 32'h0, 2'b00);

        // Reset with two loads in flight, asserted during stall with a store presented
        drive_lw(12'h010);
        tick();
        drive_lw(12'h004);
        tick();
        rst = 1'b0;
        stall = 1'b1;
        drive(mk(1, 2'b10, 0, 12'h010, 32'h00000000, 32'h0, 2'b00));
        tick();
        chk1("rst_mid", 1'b0, 32'h0, 2'b00);
        chk2("rst_mid", 1'b0, 32'h0, 2'b00);
        rst = 1'b1;
        stall = 1'b0;
        req_valid = 1'b0;
        tick();
        chk1("rst_after0", 1'b0, 32'h0, 2'b00);
        chk2("rst_after0", 1'b0, 32'h0, 2'b00);
        tick();
        chk2("rst_after1", 1'b0, 32'h0, 2'b00);
        drive_lw(12'h010);
        tick();
        chk1("rst_mem", 1'b1, 32'hF5ADBEEF, 2'b00);
        req_valid = 1'b0;
        tick();
        chk2("rst_mem", 1'b1, 32'hF5ADBEEF, 2'b00);
        chk1("rst_mem_idle", 1'b0, 32'h0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
